axi_arbiter_mtos_m2: RTL and testbench
======================================

// Module: axi_arbiter_mtos_m2
// PURPOSE
//  Master-to-slave arbiter; one instance sits in front of each slave port of the AXI interconnect.
//  Grants one of NUM masters on AR and AW, and locks W to the AW winner until WLAST is accepted.
//  Each grant is one-hot; the interconnect muxes address/data toward the slave with it.
// PARAMETERS
//  NUM  2  number of masters; all per-master vectors are [NUM-1:0]; index 0 = highest fixed priority
// PORTS
//  ACLK      in   1    clock
//  ARESETn   in   1    asynchronous, active-low reset
//  AWSELECT  in   NUM  master m addresses this slave (address decode)
//  AWVALID   in   NUM  per-master AWVALID
//  AWREADY   in   NUM  slave AWREADY routed back per master
//  AWGRANT   out  NUM  one-hot AW grant
//  WVALID    in   NUM  per-master WVALID
//  WREADY    in   NUM  slave WREADY routed back per master
//  WLAST     in   NUM  per-master WLAST
//  WGRANT    out  NUM  one-hot W grant
//  ARSELECT  in   NUM  master m addresses this slave
//  ARVALID   in   NUM  per-master ARVALID
//  ARREADY   in   NUM  slave ARREADY routed back per master
//  ARGRANT   out  NUM  one-hot AR grant
// BEHAVIOUR
//  Reset: all grants 0, stateR=AR_RUN, stateW=AW_RUN, held-grant regs 0, aw_done=w_done=0.
//  AR FSM:
//   AR_RUN: ARGRANT = sel(ARSELECT&ARVALID), combinational, zero latency.
//   AR_RUN, grant!=0 and no ARREADY on it: latch grant, go AR_WAIT. Same-cycle handshake: stay AR_RUN.
//   AR_WAIT: ARGRANT = held reg. Return to AR_RUN when |(ARGRANT&ARVALID&ARREADY).
//  AW/W FSM (one outstanding write per slave):
//   AW_RUN: AWGRANT = sel(AWSELECT&AWVALID); WGRANT = AWGRANT, so W ahead of AW is allowed.
//   AW_RUN, grant!=0: set aw_done = AW handshake, w_done = W handshake with WLAST. Both set: stay AW_RUN.
//   Otherwise latch grant and go AW_HOLD.
//   AW_HOLD: AWGRANT = held & ~aw_done; WGRANT = held & ~w_done.
//   AW_HOLD: set each flag on its handshake. When both set (same cycle allowed): clear flags, go AW_RUN.
//   Non-last W beats never release the lock. An AW grant is never withdrawn while AWVALID stays asserted.
//  Grant changes only in *_RUN. A requester dropping VALID in *_RUN simply loses its combinational grant.
//  Reset mid-burst: immediate return to reset state; no partial state survives.
// CONFIGURATION
//  AXI_ARB_ROUND_ROBIN_EN defined:
//   AR and AW each keep a last-winner pointer, updated on the completing handshake.
//   The master after the last winner has highest priority. Pointer resets to NUM-1, so master 0 is first.
//  Undefined: fixed priority, lowest index wins.
// STRUCTURE
//  Include axi_arbiter_defs.vh: state encodings (AR_RUN/AR_WAIT, AW_RUN/AW_HOLD), one-hot helpers.
//  Sub-module axi_arb_sel #(NUM): request[NUM-1:0] plus optional pointer -> one-hot grant.
//  It is instantiated once for AR and once for AW.
// TESTING
//  1 ARVALID=2'b11, ARSELECT=2'b11, ARREADY same cycle -> ARGRANT=2'b01 (fixed) and stateR stays AR_RUN.
//  2 ARVALID=2'b10, ARREADY low 3 cycles -> ARGRANT=2'b10 held 4 cycles.
//    Master 0 requests mid-wait -> no grant change.
//  3 M1 AW accepted, then 4-beat W, M0 AWVALID from cycle 1 -> WGRANT=2'b10 until 4th beat.
//    AWGRANT=2'b01 appears the cycle after WLAST.
//  4 M0 sends all W beats with WLAST before AWREADY -> w_done set, WGRANT=0.
//    AWGRANT=2'b01 holds until AWREADY, then AW_RUN.
//  5 AW handshake and WLAST handshake in the same cycle in AW_HOLD -> AW_RUN next cycle, grants 0.
//  6 With AXI_ARB_ROUND_ROBIN_EN, both masters continually requesting AR -> grants 01,10,01,10.
//    Assert ARESETn=0 mid-AW_HOLD -> all grants 0 asynchronously.

Source files
------------

// File: rtl/axi_arbiter_mtos_m2_pkg.sv
// Shared types for the master-to-slave AXI arbiter: FSM state
// encodings and a one-hot to index helper.
package axi_arbiter_mtos_m2_pkg;

  typedef enum logic {
    AR_RUN  = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_e;

  typedef enum logic {
    AW_RUN  = 1'b0,
    AW_HOLD = 1'b1
  } aw_state_e;

  function automatic logic [31:0] oh2idx(
    input logic [31:0] oh
  );
    oh2idx = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) oh2idx = 32'(i);
  endfunction

endpackage

// File: rtl/axi_arbiter_mtos_m2_sel.sv
// Rotating-priority one-hot selector. The master after ptr_i has
// top priority; ptr_i = NUM-1 gives plain fixed priority (index 0).
// Ports: req_i request vector, ptr_i last winner, gnt_o one-hot grant.
module axi_arbiter_mtos_m2_sel #(
  parameter int NUM = 2,
  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NUM-1:0] gnt_o
);

  logic [PW:0]      sh;
  logic [2*NUM-1:0] rot_dbl;
  logic [NUM-1:0]   rot_req;
  logic [NUM-1:0]   rot_gnt;
  logic [2*NUM-1:0] gnt_dbl;

  // Rotate so the top-priority master lands at bit 0, isolate the
  // lowest set bit, then rotate the grant back.
  always_comb begin
    sh      = {1'b0, ptr_i} + 1'b1;
    rot_dbl = {req_i, req_i} >> sh;
    rot_req = rot_dbl[NUM-1:0];
    rot_gnt = rot_req & (~rot_req + 1'b1);
    gnt_dbl = {rot_gnt, rot_gnt} << sh;
    gnt_o   = gnt_dbl[2*NUM-1:NUM];
  end

endmodule

// File: rtl/axi_arbiter_mtos_m2.sv
// Per-slave master-to-slave arbiter: grants AR and AW, locks W to the
// AW winner until WLAST. Round robin when AXI_ARB_ROUND_ROBIN_EN is
// defined, else fixed priority (index 0 highest).
// Ports: ACLK, ARESETn (async low); per-master AW/W/AR SELECT, VALID,
// READY, WLAST inputs; one-hot AWGRANT, WGRANT, ARGRANT outputs.
module axi_arbiter_mtos_m2
  import axi_arbiter_mtos_m2_pkg::*;
#(
  parameter int NUM = 2,
  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic [NUM-1:0] AWSELECT,
  input  logic [NUM-1:0] AWVALID,
  input  logic [NUM-1:0] AWREADY,
  output logic [NUM-1:0] AWGRANT,
  input  logic [NUM-1:0] WVALID,
  input  logic [NUM-1:0] WREADY,
  input  logic [NUM-1:0] WLAST,
  output logic [NUM-1:0] WGRANT,
  input  logic [NUM-1:0] ARSELECT,
  input  logic [NUM-1:0] ARVALID,
  input  logic [NUM-1:0] ARREADY,
  output logic [NUM-1:0] ARGRANT
);

  ar_state_e      st_r_q, st_r_d;
  logic [NUM-1:0] ar_hold_q, ar_hold_d;
  logic [NUM-1:0] ar_sel, ar_gnt;
  logic           ar_hs;

  aw_state_e      st_w_q, st_w_d;
  logic [NUM-1:0] aw_hold_q, aw_hold_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic [NUM-1:0] aw_sel, aw_gnt, w_gnt;
  logic           aw_hs, wl_hs;

  logic [PW-1:0]  ar_ptr, aw_ptr;

  axi_arbiter_mtos_m2_sel #(.NUM(NUM)) u_ar_sel (
    .req_i (ARSELECT & ARVALID),
    .ptr_i (ar_ptr),
    .gnt_o (ar_sel)
  );

  axi_arbiter_mtos_m2_sel #(.NUM(NUM)) u_aw_sel (
    .req_i (AWSELECT & AWVALID),
    .ptr_i (aw_ptr),
    .gnt_o (aw_sel)
  );

  assign ar_hs = |(ar_gnt & ARVALID & ARREADY);
  assign aw_hs = |(aw_gnt & AWVALID & AWREADY);
  assign wl_hs = |(w_gnt & WVALID & WREADY & WLAST);

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ar_ptr_q, ar_ptr_d;
  logic [PW-1:0] aw_ptr_q, aw_ptr_d;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_ptr_q <= PW'(NUM-1);
      aw_ptr_q <= PW'(NUM-1);
    end else begin
      ar_ptr_q <= ar_ptr_d;
      aw_ptr_q <= aw_ptr_d;
    end
  end

  always_comb begin
    ar_ptr_d = ar_ptr_q;
    aw_ptr_d = aw_ptr_q;
    if (ar_hs) ar_ptr_d = PW'(oh2idx(32'(ar_gnt)));
    if (aw_hs) aw_ptr_d = PW'(oh2idx(32'(aw_gnt)));
  end

  assign ar_ptr = ar_ptr_q;
  assign aw_ptr = aw_ptr_q;
`else
  assign ar_ptr = PW'(NUM-1);
  assign aw_ptr = PW'(NUM-1);
`endif

  // State registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      st_r_q    <= AR_RUN;
      ar_hold_q <= '0;
      st_w_q    <= AW_RUN;
      aw_hold_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      st_r_q    <= st_r_d;
      ar_hold_q <= ar_hold_d;
      st_w_q    <= st_w_d;
      aw_hold_q <= aw_hold_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // AR next state
  always_comb begin
    st_r_d    = st_r_q;
    ar_hold_d = ar_hold_q;
    unique case (st_r_q)
      AR_RUN: begin
        if (|ar_sel && !ar_hs) begin
          st_r_d    = AR_WAIT;
          ar_hold_d = ar_sel;
        end
      end
      AR_WAIT: begin
        if (ar_hs) begin
          st_r_d    = AR_RUN;
          ar_hold_d = '0;
        end
      end
      default: ;
    endcase
  end

  // AW/W next state: one write in flight, W locked until WLAST.
  always_comb begin
    st_w_d    = st_w_q;
    aw_hold_d = aw_hold_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (st_w_q)
      AW_RUN: begin
        if (|aw_sel && !(aw_hs && wl_hs)) begin
          st_w_d    = AW_HOLD;
          aw_hold_d = aw_sel;
          aw_done_d = aw_hs;
          w_done_d  = wl_hs;
        end
      end
      AW_HOLD: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | wl_hs;
        if (aw_done_d && w_done_d) begin
          st_w_d    = AW_RUN;
          aw_hold_d = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Grant outputs
  always_comb begin
    ar_gnt = ar_sel;
    aw_gnt = aw_sel;
    w_gnt  = aw_sel;
    if (st_r_q == AR_WAIT)
      ar_gnt = ar_hold_q;
    if (st_w_q == AW_HOLD) begin
      aw_gnt = aw_hold_q & ~{NUM{aw_done_q}};
      w_gnt  = aw_hold_q & ~{NUM{w_done_q}};
    end
  end

  // Grants are forced low while reset is asserted.
  assign ARGRANT = ar_gnt & {NUM{ARESETn}};
  assign AWGRANT = aw_gnt & {NUM{ARESETn}};
  assign WGRANT  = w_gnt & {NUM{ARESETn}};

endmodule

// File: tb/tb_axi_arbiter_mtos_m2.sv
// Scoreboard bench for axi_arbiter_mtos_m2: directed scenarios plus
// random traffic against an ownership-based reference model.
module tb_axi_arbiter_mtos_m2;

  localparam int NUM = 2;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [1:0] AWSELECT = '0, AWVALID = '0, AWREADY = '0;
  logic [1:0] WVALID = '0, WREADY = '0, WLAST = '0;
  logic [1:0] ARSELECT = '0, ARVALID = '0, ARREADY = '0;
  logic [1:0] AWGRANT, WGRANT, ARGRANT;

  axi_arbiter_mtos_m2 #(.NUM(NUM)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWSELECT(AWSELECT), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .AWGRANT(AWGRANT),
    .WVALID(WVALID), .WREADY(WREADY),
    .WLAST(WLAST), .WGRANT(WGRANT),
    .ARSELECT(ARSELECT), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .ARGRANT(ARGRANT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0] ar;
    logic [1:0] aw;
    logic [1:0] w;
    int         id;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: who owns each channel, what is still owed.
  int ar_own, ar_last, wr_own, aw_last;
  bit aw_left, w_left;

  function automatic bit b(input logic [1:0] v, input int m);
    return ((v >> m) & 2'b01) != 2'b00;
  endfunction

  function automatic logic [1:0] oh(input int m);
    return (m < 0) ? 2'b00 : 2'(1 << m);
  endfunction

  function automatic int pick(input logic [1:0] req,
                              input int last);
    for (int k = 1; k <= NUM; k++) begin
      int m;
      m = (last + k) % NUM;
      if (b(req, m)) return m;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ar_own = -1;
    wr_own = -1;
    aw_left = 0;
    w_left = 0;
    ar_last = NUM - 1;
    aw_last = NUM - 1;
  endtask

  task automatic model_step();
    exp_t e;
    int g;
    bit hs, ahs, whs;
    if (ar_own >= 0) g = ar_own;
    else g = pick(ARSELECT & ARVALID, ar_last);
    e.ar = oh(g);
    hs = (g >= 0) && b(ARVALID, g) && b(ARREADY, g);
    if (ar_own < 0 && g >= 0 && !hs) ar_own = g;
    else if (ar_own >= 0 && hs) ar_own = -1;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    if (hs) ar_last = g;
`endif
    if (wr_own < 0) begin
      g = pick(AWSELECT & AWVALID, aw_last);
      e.aw = oh(g);
      e.w = oh(g);
      if (g >= 0) begin
        ahs = b(AWVALID, g) && b(AWREADY, g);
        whs = b(WVALID, g) && b(WREADY, g) && b(WLAST, g);
        if (!(ahs && whs)) begin
          wr_own = g;
          aw_left = !ahs;
          w_left = !whs;
        end
`ifdef AXI_ARB_ROUND_ROBIN_EN
        if (ahs) aw_last = g;
`endif
      end
    end else begin
      g = wr_own;
      e.aw = aw_left ? oh(g) : 2'b00;
      e.w = w_left ? oh(g) : 2'b00;
      ahs = aw_left && b(AWVALID, g) && b(AWREADY, g);
      whs = w_left && b(WVALID, g) && b(WREADY, g)
            && b(WLAST, g);
      if (ahs) aw_left = 0;
      if (whs) w_left = 0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      if (ahs) aw_last = g;
`endif
      if (!aw_left && !w_left) wr_own = -1;
    end
    e.id = cyc;
    sb.push_back(e);
  endtask

  task automatic drive(
    input logic [1:0] arsel, arv, arr,
    input logic [1:0] awsel, awv, awr,
    input logic [1:0] wv, wr, wl
  );
    @(posedge ACLK);
    #1;
    ARSELECT = arsel; ARVALID = arv; ARREADY = arr;
    AWSELECT = awsel; AWVALID = awv; AWREADY = awr;
    WVALID = wv; WREADY = wr; WLAST = wl;
    #2;
    model_step();
    cyc++;
  endtask

  // Reset asserted with inputs still active; grants must drop at once.
  task automatic do_reset();
    exp_t e;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    e.ar = 2'b00;
    e.aw = 2'b00;
    e.w = 2'b00;
    e.id = cyc;
    sb.push_back(e);
    model_reset();
    #6;
    ARESETn = 1'b1;
    ARSELECT = '0; ARVALID = '0; ARREADY = '0;
    AWSELECT = '0; AWVALID = '0; AWREADY = '0;
    WVALID = '0; WREADY = '0; WLAST = '0;
    cyc++;
  endtask

  task automatic check(input string n, input logic [1:0] act,
                       input logic [1:0] exp, input int id);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b",
               n, id, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ARGRANT", ARGRANT, e.ar, e.id);
        check("AWGRANT", AWGRANT, e.aw, e.id);
        check("WGRANT", WGRANT, e.w, e.id);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [1:0] rdy();
    return {1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0)};
  endfunction

  initial begin
    model_reset();
    do_reset();
    // Same-cycle AR handshake, then a new requester straight away.
    drive(2'b11, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0);
    drive(2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(2'b10, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    // AR held through a wait, master 0 joins mid-wait.
    drive(2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0);
    do_reset();
    // M1 AW accepted, 4-beat W lock while M0 waits.
    drive(0, 0, 0, 2'b10, 2'b10, 2'b10, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 2'b01, 0, 2'b10, 2'b10, 2'b00);
    drive(0, 0, 0, 2'b01, 2'b01, 0, 2'b10, 2'b10, 2'b00);
    drive(0, 0, 0, 2'b01, 2'b01, 0, 2'b10, 2'b10, 2'b00);
    drive(0, 0, 0, 2'b01, 2'b01, 0, 2'b10, 2'b10, 2'b10);
    drive(0, 0, 0, 2'b01, 2'b01, 2'b01, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01);
    // W completes ahead of AW.
    drive(0, 0, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 2'b00);
    drive(0, 0, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 2'b01);
    drive(0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 2'b01, 2'b01, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // AW and WLAST handshake together in hold.
    drive(0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Continuous AR from both masters.
    repeat (4) drive(2'b11, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a held write.
    drive(0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b10, 2'b10, 0, 2'b10, 2'b10, 0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 128 == 127) do_reset();
      drive(2'($urandom), 2'($urandom), rdy(),
            2'($urandom), 2'($urandom), rdy(),
            2'($urandom), rdy(), 2'($urandom));
    end
    @(posedge ACLK);
    @(negedge ACLK);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
